// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I main controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR_ADR = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_TIMEOUT = 2'b10
  } trap_cause_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Purely state-derived control word; input-gated strobes are added in the top.
  typedef struct packed {
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic       instr_done;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read   = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_JALR_ADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.adr_src  = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_MEMDATA;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_RTYPE;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ITYPE;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_BRANCH;
        c.result_src = RES_ALUOUT;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_mem_watchdog.sv
// Memory wait watchdog: counts consecutive stalled cycles and flags the
// cycle on which the stall limit is reached. MEM_TIMEOUT=0 disables it.
module mc_mem_watchdog
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam bit ENABLED = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt_q;
  logic             stalled;

  assign stalled = waiting && !mem_ready;
  // mem_ready high on the limit cycle suppresses the timeout via stalled.
  assign timeout = ENABLED && stalled && (cnt_q == CNT_LAST);

  // Leaving a wait state always coincides with !stalled or timeout, so this also clears on state change.
  always_ff @(posedge clk) begin
    if (reset || !ENABLED || !stalled || timeout) cnt_q <= '0;
    else                                          cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I main control unit with memory handshake stalls,
// bus-timeout watchdog and sticky trap.
//
// state      | meaning
// -----------+--------------------------------------------------
// FETCH      | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE     | decode opcode, OldPC+imm -> ALUOut
// MEMADR     | rs1+imm -> ALUOut (load/store address)
// MEMREAD    | read data at ALUOut, wait for mem_ready
// MEMWB      | MemData -> rd
// MEMWRITE   | write rs2 at ALUOut, wait for mem_ready
// EXEC_R     | rs1 op rs2
// EXEC_I     | rs1 op imm
// ALUWB      | ALUOut -> rd
// BRANCH     | compare, ALUOut -> PC when taken
// JALR_ADR   | rs1+imm -> ALUOut
// JUMP       | ALUOut -> PC, OldPC+4 -> ALUOut
// TRAP       | illegal opcode or bus timeout, held until reset
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_o
);

  state_t      state_q, state_d;
  ctrl_t       ctrl_q;
  trap_cause_t cause_q;
  logic        trap_q;
  logic        waiting;
  logic        timeout;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

  mc_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .waiting  (waiting),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  // Next-state decode; mem_ready is only consulted in the three wait states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JUMP;
          OP_JALR:           state_d = S_JALR_ADR;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (Opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_TRAP;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_TRAP;
      end
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR_ADR: state_d = S_JUMP;
      S_JUMP:     state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // State register with the control word registered alongside it from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH);
      trap_q  <= 1'b0;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
      trap_q  <= (state_d == S_TRAP);
      if (state_d == S_TRAP && state_q != S_TRAP)
        cause_q <= (state_q == S_DECODE) ? TC_ILLEGAL : TC_TIMEOUT;
    end
  end

  // Enables are masked during reset so an aborted instruction makes no writes.
  assign PCWrite    = !reset && (ctrl_q.pc_write
                                 || (state_q == S_FETCH  && mem_ready)
                                 || (state_q == S_BRANCH && branch_taken));
  assign IRWrite    = !reset && (state_q == S_FETCH) && mem_ready;
  assign MemRead    = !reset && ctrl_q.mem_read;
  assign MemWrite   = !reset && ctrl_q.mem_write;
  assign RegWrite   = !reset && ctrl_q.reg_write;
  assign instr_done = !reset && (ctrl_q.instr_done || (state_q == S_MEMWRITE && mem_ready));
  assign AdrSrc     = ctrl_q.adr_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ALUOp      = ctrl_q.alu_op;
  assign ResultSrc  = ctrl_q.result_src;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: default watchdog instance plus a
// MEM_TIMEOUT=4 instance sharing the same stimulus.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       branch_taken;
  logic       mem_ready;

  logic       PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic       instr_done, trap;
  logic [1:0] trap_cause;
  logic [3:0] state_o;

  logic       t4_PCWrite, t4_IRWrite, t4_AdrSrc, t4_MemRead, t4_MemWrite, t4_RegWrite;
  logic [1:0] t4_ALUSrcA, t4_ALUSrcB, t4_ALUOp, t4_ResultSrc;
  logic       t4_instr_done, t4_trap;
  logic [1:0] t4_trap_cause;
  logic [3:0] t4_state_o;

  int checks = 0;
  int errors = 0;
  int ncyc, done_cnt, mw_seen, bad;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .instr_done(instr_done),
    .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  mc_controller #(.MEM_TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .PCWrite(t4_PCWrite), .IRWrite(t4_IRWrite), .AdrSrc(t4_AdrSrc),
    .MemRead(t4_MemRead), .MemWrite(t4_MemWrite), .RegWrite(t4_RegWrite),
    .ALUSrcA(t4_ALUSrcA), .ALUSrcB(t4_ALUSrcB), .ALUOp(t4_ALUOp),
    .ResultSrc(t4_ResultSrc), .instr_done(t4_instr_done), .trap(t4_trap),
    .trap_cause(t4_trap_cause), .state_o(t4_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, apply this cycle's inputs, then sample.
  task automatic cyc(input logic rdy, input logic bt);
    @(posedge clk);
    #1;
    mem_ready    = rdy;
    branch_taken = bt;
    #1;
    ncyc++;
    done_cnt += int'(instr_done);
    mw_seen  += int'(MemWrite);
  endtask

  task automatic start_instr(input logic [6:0] op);
    Opcode = op;
    cyc(1'b1, 1'b0);
    ncyc     = 1;
    done_cnt = 0;
    mw_seen  = 0;
    chk("start_fetch", 32'(state_o), 32'(S_FETCH));
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; branch_taken = 1'b0; Opcode = OP_RTYPE;
    #1;
    chk("rst_pcwrite_masked", 32'(PCWrite), 32'd0);
    chk("rst_irwrite_masked", 32'(IRWrite), 32'd0);
    @(posedge clk); #1;
    chk("rst_state", 32'(state_o), 32'(S_FETCH));
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_cause", 32'(trap_cause), 32'd0);
    chk("rst_memread_masked", 32'(MemRead), 32'd0);
    reset = 1'b0;
    #1;
    chk("fetch_memread", 32'(MemRead), 32'd1);
    chk("fetch_irwrite", 32'(IRWrite), 32'd1);
    chk("fetch_pcwrite", 32'(PCWrite), 32'd1);
    chk("fetch_srcb", 32'(ALUSrcB), 32'(SRCB_FOUR));
    chk("fetch_result", 32'(ResultSrc), 32'(RES_ALU));
    ncyc = 1; done_cnt = 0; mw_seen = 0;

    // R-type, no wait states
    chk("r_c1_regwrite", 32'(RegWrite), 32'd0);
    cyc(1'b1, 1'b0);
    chk("r_decode", 32'(state_o), 32'(S_DECODE));
    chk("r_decode_srca", 32'(ALUSrcA), 32'(SRCA_OLDPC));
    chk("r_decode_srcb", 32'(ALUSrcB), 32'(SRCB_IMM));
    chk("r_c2_regwrite", 32'(RegWrite), 32'd0);
    cyc(1'b1, 1'b0);
    chk("r_exec", 32'(state_o), 32'(S_EXEC_R));
    chk("r_exec_aluop", 32'(ALUOp), 32'(ALUOP_RTYPE));
    chk("r_exec_srca", 32'(ALUSrcA), 32'(SRCA_RS1));
    chk("r_c3_regwrite", 32'(RegWrite), 32'd0);
    cyc(1'b1, 1'b0);
    chk("r_aluwb", 32'(state_o), 32'(S_ALUWB));
    chk("r_c4_regwrite", 32'(RegWrite), 32'd1);
    chk("r_done_count", 32'(done_cnt), 32'd1);
    chk("r_cycles", 32'(ncyc), 32'd4);

    // Load with three stalled cycles in MEMREAD
    start_instr(OP_LOAD);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("ld_memadr", 32'(state_o), 32'(S_MEMADR));
    cyc(1'b0, 1'b0);
    chk("ld_memread", 32'(state_o), 32'(S_MEMREAD));
    chk("ld_adrsrc", 32'(AdrSrc), 32'd1);
    chk("ld_memread_en", 32'(MemRead), 32'd1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("ld_still_memread", 32'(state_o), 32'(S_MEMREAD));
    cyc(1'b1, 1'b0);
    chk("ld_memwb", 32'(state_o), 32'(S_MEMWB));
    chk("ld_result", 32'(ResultSrc), 32'(RES_MEMDATA));
    chk("ld_regwrite", 32'(RegWrite), 32'd1);
    chk("ld_cycles", 32'(ncyc), 32'd8);
    chk("ld_no_memwrite", 32'(mw_seen), 32'd0);
    chk("ld_done_count", 32'(done_cnt), 32'd1);

    // Store with one stalled cycle in MEMWRITE
    start_instr(OP_STORE);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("st_memwrite", 32'(state_o), 32'(S_MEMWRITE));
    chk("st_wait_done", 32'(instr_done), 32'd0);
    chk("st_memwrite_en", 32'(MemWrite), 32'd1);
    cyc(1'b1, 1'b0);
    chk("st_ready_done", 32'(instr_done), 32'd1);
    chk("st_cycles", 32'(ncyc), 32'd5);

    // Branch taken / not taken
    start_instr(OP_BRANCH);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("bt_state", 32'(state_o), 32'(S_BRANCH));
    chk("bt_pcwrite", 32'(PCWrite), 32'd1);
    chk("bt_aluop", 32'(ALUOp), 32'(ALUOP_BRANCH));
    chk("bt_done", 32'(instr_done), 32'd1);
    chk("bt_cycles", 32'(ncyc), 32'd3);
    start_instr(OP_BRANCH);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("bn_pcwrite", 32'(PCWrite), 32'd0);
    chk("bn_done", 32'(instr_done), 32'd1);
    chk("bn_cycles", 32'(ncyc), 32'd3);

    // JAL
    start_instr(OP_JAL);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("jal_jump", 32'(state_o), 32'(S_JUMP));
    cyc(1'b1, 1'b0);
    chk("jal_aluwb", 32'(state_o), 32'(S_ALUWB));
    chk("jal_cycles", 32'(ncyc), 32'd4);

    // JALR
    start_instr(OP_JALR);
    cyc(1'b1, 1'b0);
    chk("jalr_decode", 32'(state_o), 32'(S_DECODE));
    cyc(1'b1, 1'b0);
    chk("jalr_adr", 32'(state_o), 32'(S_JALR_ADR));
    chk("jalr_adr_srca", 32'(ALUSrcA), 32'(SRCA_RS1));
    cyc(1'b1, 1'b0);
    chk("jalr_jump", 32'(state_o), 32'(S_JUMP));
    chk("jalr_jump_pcwrite", 32'(PCWrite), 32'd1);
    chk("jalr_jump_srcb", 32'(ALUSrcB), 32'(SRCB_FOUR));
    cyc(1'b1, 1'b0);
    chk("jalr_aluwb", 32'(state_o), 32'(S_ALUWB));
    chk("jalr_regwrite", 32'(RegWrite), 32'd1);
    chk("jalr_result", 32'(ResultSrc), 32'(RES_ALUOUT));
    chk("jalr_cycles", 32'(ncyc), 32'd5);

    // Illegal opcode traps and holds
    start_instr(7'b0000000);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("ill_state", 32'(state_o), 32'(S_TRAP));
    chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_cause", 32'(trap_cause), 32'(TC_ILLEGAL));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(i[0], 1'b1);
      if (state_o !== S_TRAP || trap !== 1'b1 || PCWrite || IRWrite || MemRead
          || MemWrite || RegWrite || instr_done) bad++;
    end
    chk("ill_hold_20", 32'(bad), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("ill_reset_state", 32'(state_o), 32'(S_FETCH));
    chk("ill_reset_trap", 32'(trap), 32'd0);
    chk("ill_reset_cause", 32'(trap_cause), 32'd0);

    // MEM_TIMEOUT=4: stuck mem_ready traps after four wait cycles
    Opcode = OP_RTYPE;
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("to_wait4_fetch", 32'(t4_state_o), 32'(S_FETCH));
    cyc(1'b0, 1'b0);
    chk("to_trap_state", 32'(t4_state_o), 32'(S_TRAP));
    chk("to_trap", 32'(t4_trap), 32'd1);
    chk("to_cause", 32'(t4_trap_cause), 32'(TC_TIMEOUT));
    chk("to_default_waits", 32'(state_o), 32'(S_FETCH));
    chk("to_default_notrap", 32'(trap), 32'd0);

    // mem_ready on the fourth wait cycle wins over the timeout
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("race_irwrite", 32'(t4_IRWrite), 32'd1);
    cyc(1'b1, 1'b0);
    chk("race_decode", 32'(t4_state_o), 32'(S_DECODE));
    chk("race_notrap", 32'(t4_trap), 32'd0);

    // Reset mid-store suppresses the write
    Opcode = OP_STORE;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("mid_memwrite", 32'(MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_masked", 32'(MemWrite), 32'd0);
    @(posedge clk); #1;
    chk("mid_reset_fetch", 32'(state_o), 32'(S_FETCH));
    chk("mid_reset_no_write", 32'(MemWrite), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
